// File: rtl/riscv_biu_responder.sv
// BIU-side responder for the CPU data bus: in-order request queue
// serviced from a word-addressed scratch memory after a fixed latency.
module riscv_biu_responder #(
    parameter int XLEN      = 64,
    parameter int PLEN      = 64,
    parameter int DEPTH     = 2,
    parameter int MEM_ABITS = 10,
    parameter int LATENCY   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic            biu_lock_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o,
    input  logic            wait_i
);
    localparam int NB  = XLEN / 8;
    localparam int OB  = $clog2(NB);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW  = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam int MW  = 1 << MEM_ABITS;
    localparam int TOP = MEM_ABITS + OB;

    logic [PLEN-1:0] q_adr  [DEPTH];
    logic [2:0]      q_size [DEPTH];
    logic [XLEN-1:0] q_d    [DEPTH];
    logic [6:0]      q_attr [DEPTH];
    logic [AW-1:0]   q_age  [DEPTH];
    logic [DEPTH-1:0] q_we;
    logic [DEPTH-1:0] q_err;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [XLEN-1:0] mem [MW];

    logic                 push;
    logic                 pop;
    logic                 req_bad;
    logic [MEM_ABITS-1:0] widx;
    logic [NB-1:0]        wmask;
    logic                 unused_attr;

    function automatic logic chk_err(input logic [PLEN-1:0] a,
                                     input logic [2:0] s);
        logic bad;
        bad = (int'(s) > OB);
        for (int i = 0; i < 8; i++)
            if (i < int'(s) && a[i])
                bad = 1'b1;
        for (int i = TOP; i < PLEN; i++)
            if (a[i])
                bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [OB-1:0] off,
                                                input logic [2:0] s);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++)
            if (b >= int'(off) && b < int'(off) + (1 << s))
                m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full queue refuses even when the head retires this cycle.
    assign biu_stb_ack_o = biu_stb_i & (count < CW'(DEPTH)) & ~rst_i;
    assign push    = biu_stb_i & biu_stb_ack_o;
    assign pop     = (count != '0) & (q_age[head] == AW'(LATENCY))
                   & ~wait_i & ~rst_i;
    assign req_bad = chk_err(biu_adri_i, biu_size_i);
    assign widx    = q_adr[head][OB +: MEM_ABITS];
    assign wmask   = lane_mask(q_adr[head][OB-1:0], q_size[head]);
    assign unused_attr = ^q_attr[head];

    always_comb begin
        biu_ack_o  = 1'b0;
        biu_err_o  = 1'b0;
        biu_q_o    = '0;
        biu_adro_o = '0;
        if (pop) begin
            biu_adro_o = q_adr[head];
            if (q_err[head]) begin
                biu_err_o = 1'b1;
            end else begin
                biu_ack_o = 1'b1;
                if (!q_we[head])
                    biu_q_o = mem[widx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= nxt(tail);
            if (pop)
                head <= nxt(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: slots are only read while counted valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++)
            if (q_age[i] != AW'(LATENCY))
                q_age[i] <= q_age[i] + 1'b1;
        if (push) begin
            q_adr[tail]  <= biu_adri_i;
            q_size[tail] <= biu_size_i;
            q_d[tail]    <= biu_d_i;
            q_attr[tail] <= {biu_type_i, biu_lock_i, biu_prot_i};
            q_we[tail]   <= biu_we_i;
            q_err[tail]  <= req_bad;
            q_age[tail]  <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop && !q_err[head] && q_we[head])
            for (int b = 0; b < NB; b++)
                if (wmask[b])
                    mem[widx][8*b +: 8] <= q_d[head][8*b +: 8];
    end
endmodule
